triangle_queue: RTL and testbench

- Responder end of the triangle_valid/triangle_ready submission handshake.
- Accepts triangle descriptors from the AXI register block or a bench: three screen vertices, RGB332 colour, 8.24 inv_area, and three 16-bit depths.
- Buffers descriptors in a FIFO and issues them one at a time to the rasterizer. Each issue is a start pulse; the block then waits for rasterizer_done.
- Sits between the AXI slave register file and the rasterizer/z-buffer path, in the axi_aclk domain.

---
 rtl/gpu_pkg.sv | 25 ++
 rtl/tri_fifo_mem.sv | 22 ++
 rtl/triangle_queue.sv | 86 ++++++++
 tb/tb_triangle_queue.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared triangle descriptor layout and queue state encoding.
package gpu_pkg;
    localparam int X_W        = 9;
    localparam int Y_W        = 8;
    localparam int COLOR_W    = 8;
    localparam int INV_AREA_W = 32;
    localparam int Z_W        = 16;
    localparam int TRI_DESC_W = 3 * (X_W + Y_W) + COLOR_W + INV_AREA_W + 3 * Z_W;

    typedef struct packed {
        logic [X_W-1:0]        v1x;
        logic [Y_W-1:0]        v1y;
        logic [X_W-1:0]        v2x;
        logic [Y_W-1:0]        v2y;
        logic [X_W-1:0]        v3x;
        logic [Y_W-1:0]        v3y;
        logic [COLOR_W-1:0]    color;
        logic [INV_AREA_W-1:0] inv_area;
        logic [Z_W-1:0]        z1;
        logic [Z_W-1:0]        z2;
        logic [Z_W-1:0]        z3;
    } tri_desc_t;

    typedef enum logic {Q_IDLE, Q_BUSY} q_state_e;
endpackage

// File: rtl/tri_fifo_mem.sv
// tri_fifo_mem: descriptor storage, synchronous write and asynchronous read.
module tri_fifo_mem
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  tri_desc_t     i_wdata,
    input  logic [AW-1:0] i_raddr,
    output tri_desc_t     o_rdata
);
    tri_desc_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/triangle_queue.sv
// triangle_queue: buffers triangle descriptors and issues them one at a time
// to the rasterizer, waiting for rasterizer_done between issues.
module triangle_queue
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             axi_aclk,
    input  logic             axi_aresetn,
    input  logic             triangle_valid,
    output logic             triangle_ready,
    input  tri_desc_t        in_tri,
    input  logic             flush,
    output tri_desc_t        rast_tri,
    output logic             rast_start,
    input  logic             rasterizer_done,
    output logic [CNT_W-1:0] occupancy,
    output logic             busy,
    output logic             all_idle,
    output logic [15:0]      drop_count
);
    localparam int AW = $clog2(DEPTH);

    q_state_e         r_state, w_state_nxt;
    logic [CNT_W-1:0] r_wr_ptr, r_rd_ptr, r_occ;
    logic [CNT_W-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt, w_occ_nxt;
    logic             r_start, r_all_idle;
    logic [15:0]      r_drop;
    tri_desc_t        r_tri, w_mem_rd;
    logic             w_accept, w_push, w_issue, w_done;

    // zero inv_area marks a degenerate triangle: accepted, counted, never stored
    assign w_accept = triangle_valid && triangle_ready;
    assign w_push   = w_accept && (in_tri.inv_area != '0);
    assign w_issue  = (r_state == Q_IDLE) && (r_occ != '0) && !flush;
    assign w_done   = (r_state == Q_BUSY) && !r_start && rasterizer_done;

    tri_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (axi_aclk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (in_tri),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_mem_rd)
    );

    always_comb begin
        w_state_nxt  = w_issue ? Q_BUSY : (w_done ? Q_IDLE : r_state);
        w_wr_ptr_nxt = r_wr_ptr + CNT_W'(w_push);
        w_rd_ptr_nxt = flush ? r_wr_ptr : r_rd_ptr + CNT_W'(w_issue);
        w_occ_nxt    = flush ? '0 : r_occ + CNT_W'(w_push) - CNT_W'(w_issue);
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state    <= Q_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_start    <= 1'b0;
            r_all_idle <= 1'b1;
            r_drop     <= '0;
            r_tri      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_occ      <= w_occ_nxt;
            r_start    <= w_issue;
            r_all_idle <= (w_occ_nxt == '0) && (w_state_nxt == Q_IDLE);
            if (w_issue) r_tri <= w_mem_rd;
            if (w_accept && !w_push && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
        end
    end

    always_comb begin
        triangle_ready = axi_aresetn && (r_occ != CNT_W'(DEPTH)) && !flush;
        busy           = r_state == Q_BUSY;
        rast_start     = r_start;
        rast_tri       = r_tri;
        occupancy      = r_occ;
        all_idle       = r_all_idle;
        drop_count     = r_drop;
    end
endmodule

// File: tb/tb_triangle_queue.sv
// tb_triangle_queue: scoreboard bench; expected descriptors are queued on push
// and compared against rast_tri on every rast_start pulse.
module tb_triangle_queue;
    import gpu_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             axi_aclk, axi_aresetn, triangle_valid, triangle_ready;
    logic             flush, rast_start, rasterizer_done, busy, all_idle;
    tri_desc_t        in_tri, rast_tri;
    logic [CNT_W-1:0] occupancy;
    logic [15:0]      drop_count;

    int        n_checks = 0;
    int        n_errors = 0;
    int        n_starts = 0;
    tri_desc_t sb [$];

    triangle_queue #(.DEPTH(DEPTH)) dut (
        .axi_aclk        (axi_aclk),
        .axi_aresetn     (axi_aresetn),
        .triangle_valid  (triangle_valid),
        .triangle_ready  (triangle_ready),
        .in_tri          (in_tri),
        .flush           (flush),
        .rast_tri        (rast_tri),
        .rast_start      (rast_start),
        .rasterizer_done (rasterizer_done),
        .occupancy       (occupancy),
        .busy            (busy),
        .all_idle        (all_idle),
        .drop_count      (drop_count)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    task automatic chk(input string tag, input logic [TRI_DESC_W-1:0] got, input logic [TRI_DESC_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge axi_aclk) begin
        if (rast_start) begin
            n_starts++;
            if (sb.size() == 0) chk("unexpected_start", rast_start, 1'b0);
            else chk("rast_tri", rast_tri, sb.pop_front());
        end
    end

    function automatic tri_desc_t mk(input int i);
        tri_desc_t d;
        d.v1x      = 9'(i * 3);
        d.v1y      = 8'(i * 5);
        d.v2x      = 9'(i * 7 + 100);
        d.v2y      = 8'(i + 50);
        d.v3x      = 9'(i * 11);
        d.v3y      = 8'(255 - i);
        d.color    = 8'(i * 17);
        d.inv_area = 32'h1000 + 32'(i);
        d.z1       = 16'(i * 100);
        d.z2       = 16'(i * 200 + 1);
        d.z3       = 16'(~i);
        return d;
    endfunction

    task automatic push(input tri_desc_t d);
        int n = 0;
        triangle_valid = 1'b1;
        in_tri = d;
        while (!triangle_ready && n < 200) begin
            @(posedge axi_aclk); #1;
            n++;
        end
        if (!triangle_ready) chk("push_timeout", triangle_ready, 1'b1);
        else begin
            if (d.inv_area != '0) sb.push_back(d);
            @(posedge axi_aclk); #1;
        end
        triangle_valid = 1'b0;
    endtask

    task automatic done_pulse();
        int n = 0;
        while (!(busy && !rast_start) && n < 200) begin
            @(posedge axi_aclk); #1;
            n++;
        end
        if (!(busy && !rast_start)) chk("done_wait", busy, 1'b1);
        else begin
            rasterizer_done = 1'b1;
            @(posedge axi_aclk); #1;
            rasterizer_done = 1'b0;
        end
    endtask

    initial begin
        tri_desc_t t1, tx, ty;
        int s0;
        axi_aresetn = 1'b0;
        triangle_valid = 1'b0;
        flush = 1'b0;
        rasterizer_done = 1'b0;
        in_tri = '0;
        repeat (3) @(posedge axi_aclk);
        #1;
        chk("rst_ready", triangle_ready, 1'b0);
        chk("rst_start", rast_start, 1'b0);
        chk("rst_occ", occupancy, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_all_idle", all_idle, 1'b1);
        chk("rst_drop", drop_count, 0);
        chk("rst_tri", rast_tri, 0);
        axi_aresetn = 1'b1;
        @(posedge axi_aclk); #1;
        chk("ready_after_rst", triangle_ready, 1'b1);

        // single triangle: issue latency, descriptor, completion
        t1 = '{v1x: 9'd40, v1y: 8'd20, v2x: 9'd140, v2y: 8'd120, v3x: 9'd40, v3y: 8'd120,
               color: 8'hE0, inv_area: 32'h0000068D, z1: 16'd50, z2: 16'd50, z3: 16'd50};
        push(t1);
        chk("lat_no_start_yet", rast_start, 1'b0);
        chk("all_idle_falls_on_push", all_idle, 1'b0);
        chk("occ_after_push", occupancy, 1);
        @(posedge axi_aclk); #1;
        chk("lat_start", rast_start, 1'b1);
        chk("busy_on_issue", busy, 1'b1);
        chk("occ_after_issue", occupancy, 0);
        @(posedge axi_aclk); #1;
        chk("start_one_cycle", rast_start, 1'b0);
        repeat (18) @(posedge axi_aclk);
        #1;
        rasterizer_done = 1'b1;
        @(posedge axi_aclk); #1;
        rasterizer_done = 1'b0;
        chk("busy_after_done", busy, 1'b0);
        chk("all_idle_after_done", all_idle, 1'b1);
        chk("rast_tri_stable", rast_tri, t1);

        // fill the queue while the rasterizer is stalled
        s0 = n_starts;
        for (int i = 1; i <= 8; i++) push(mk(i));
        chk("occ_after_8", occupancy, 7);
        chk("ready_not_full", triangle_ready, 1'b1);
        push(mk(9));
        chk("occ_full", occupancy, 8);
        chk("ready_full", triangle_ready, 1'b0);
        fork
            push(mk(10));
            begin
                repeat (3) @(posedge axi_aclk);
                #1;
                chk("occ_held", occupancy, 8);
                chk("ready_held", triangle_ready, 1'b0);
                done_pulse();
            end
        join
        chk("occ_refilled", occupancy, 8);
        for (int i = 0; i < 9; i++) done_pulse();
        repeat (3) @(posedge axi_aclk);
        #1;
        chk("fill_starts", n_starts - s0, 10);
        chk("fill_sb_empty", sb.size(), 0);
        chk("fill_all_idle", all_idle, 1'b1);

        // degenerate triangle dropped between two valid ones
        s0 = n_starts;
        tx = mk(20);
        tx.inv_area = '0;
        push(mk(21));
        push(tx);
        push(mk(22));
        chk("drop_count", drop_count, 1);
        done_pulse();
        done_pulse();
        repeat (3) @(posedge axi_aclk);
        #1;
        chk("degen_starts", n_starts - s0, 2);
        chk("degen_sb_empty", sb.size(), 0);

        // flush with one in flight and three queued
        s0 = n_starts;
        for (int i = 30; i < 34; i++) push(mk(i));
        chk("occ_before_flush", occupancy, 3);
        flush = 1'b1;
        #1;
        chk("ready_during_flush", triangle_ready, 1'b0);
        @(posedge axi_aclk); #1;
        flush = 1'b0;
        sb.delete();
        chk("occ_after_flush", occupancy, 0);
        chk("busy_through_flush", busy, 1'b1);
        done_pulse();
        repeat (8) @(posedge axi_aclk);
        #1;
        chk("flush_starts", n_starts - s0, 1);
        chk("flush_busy_done", busy, 1'b0);
        chk("flush_all_idle", all_idle, 1'b1);

        // done ignored while idle and during the start cycle
        s0 = n_starts;
        rasterizer_done = 1'b1;
        @(posedge axi_aclk); #1;
        rasterizer_done = 1'b0;
        chk("done_idle_busy", busy, 1'b0);
        chk("done_idle_starts", n_starts - s0, 0);
        tx = mk(40);
        ty = mk(41);
        push(tx);
        push(ty);
        chk("start_cycle", rast_start, 1'b1);
        rasterizer_done = 1'b1;
        @(posedge axi_aclk); #1;
        chk("done_in_start_ignored", busy, 1'b1);
        @(posedge axi_aclk); #1;
        rasterizer_done = 1'b0;
        chk("done_honoured", busy, 1'b0);
        chk("gap_cycle", rast_start, 1'b0);
        @(posedge axi_aclk); #1;
        chk("issue_after_gap", rast_start, 1'b1);
        done_pulse();
        repeat (2) @(posedge axi_aclk);
        #1;

        // asynchronous reset mid-flight with two queued
        for (int i = 50; i < 53; i++) push(mk(i));
        chk("occ_before_rst", occupancy, 2);
        axi_aresetn = 1'b0;
        sb.delete();
        #2;
        chk("arst_busy", busy, 1'b0);
        chk("arst_occ", occupancy, 0);
        chk("arst_all_idle", all_idle, 1'b1);
        chk("arst_ready", triangle_ready, 1'b0);
        chk("arst_tri", rast_tri, 0);
        chk("arst_drop", drop_count, 0);
        repeat (2) @(posedge axi_aclk);
        #1;
        axi_aresetn = 1'b1;
        s0 = n_starts;
        repeat (10) @(posedge axi_aclk);
        #1;
        chk("no_start_after_rst", n_starts - s0, 0);
        chk("ready_after_arst", triangle_ready, 1'b1);
        push(mk(60));
        done_pulse();
        repeat (3) @(posedge axi_aclk);
        #1;
        chk("post_rst_starts", n_starts - s0, 1);
        chk("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
